// File: rtl/lh_message_streamer_if.sv
// Bus bundle between the host/testbench and the light-hash message streamer.
// The slave modport is the streamer; the master modport is its host side.
interface lh_message_streamer_if;
  // Host write port and control.
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        start;
  // Hash core return path.
  logic [63:0] digest_in;
  logic        digest_ready_in;
  logic        err_invalid_in;
  // Streamer outputs.
  // Handshake: message_valid qualifies message_byte for exactly one cycle and
  // the core has no ready/backpressure, so a byte is consumed whenever valid=1.
  logic [7:0]  message_byte;
  logic        message_valid;
  logic        busy;
  logic        wr_full;
  logic [5:0]  msg_len;
  logic [63:0] digest_out;
  logic        done;
  logic        err_char;
  logic        err_abort;
  logic [1:0]  dbg_state;

  modport slave (
    input  wr_en, wr_data, start, digest_in, digest_ready_in, err_invalid_in,
    output message_byte, message_valid, busy, wr_full, msg_len, digest_out,
           done, err_char, err_abort, dbg_state
  );

  modport master (
    output wr_en, wr_data, start, digest_in, digest_ready_in, err_invalid_in,
    input  message_byte, message_valid, busy, wr_full, msg_len, digest_out,
           done, err_char, err_abort, dbg_state
  );
endinterface

// File: rtl/lh_message_streamer.sv
// Buffers a filtered ASCII message, streams HEAD/bytes/TAIL to the light-hash
// core with a fixed inter-byte gap, then waits for and captures the digest.
module lh_message_streamer #(
  parameter int         MAX_LEN    = 32,
  parameter logic [7:0] HEAD       = 8'hFF,
  parameter logic [7:0] TAIL       = 8'h00,
  parameter int         GAP_CYCLES = 1,
  parameter int         TIMEOUT    = 64
) (
  input logic clk,
  input logic rst,
  lh_message_streamer_if.slave lh_if
);
  localparam int            AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);
  localparam logic [3:0]    GAP      = 4'(GAP_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_len, w_len_nxt;
  logic [6:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_gap, w_gap_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy;
  logic          r_full;
  logic [63:0]   r_digest, w_digest_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err_char, w_err_char_nxt;
  logic          r_err_abort, w_err_abort_nxt;
  logic          w_wr_accept;
  logic          w_char_ok;
  logic [6:0]    w_len_ext;
  logic [7:0]    w_rd_byte;
  logic [7:0]    r_buf [MAX_LEN];

  assign w_char_ok = ((lh_if.wr_data >= 8'h20) && (lh_if.wr_data <= 8'h7E)) ||
                     ((lh_if.wr_data >= 8'hA1) && (lh_if.wr_data <= 8'hFE));
  assign w_len_ext = {1'b0, r_len};
  // r_idx counts frame items already emitted; item i (1..len) is buffer[i-1].
  assign w_rd_byte = r_buf[AW'(r_idx - 7'd1)];

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_gap_nxt       = r_gap;
    w_tmo_nxt       = r_tmo;
    w_byte_nxt      = r_byte;
    w_valid_nxt     = 1'b0;
    w_digest_nxt    = r_digest;
    w_done_nxt      = 1'b0;
    w_err_char_nxt  = 1'b0;
    w_err_abort_nxt = 1'b0;
    w_wr_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A full buffer drops every write silently, valid character or not.
        if (lh_if.wr_en && (r_len != LEN_MAX)) begin
          if (w_char_ok) begin
            w_wr_accept = 1'b1;
            w_len_nxt   = r_len + 6'd1;
          end else begin
            w_err_char_nxt = 1'b1;
          end
        end
        if (lh_if.start) begin
          w_state_nxt = ST_SEND;
          w_byte_nxt  = HEAD;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = 7'd1;
          w_gap_nxt   = GAP;
        end
      end
      ST_SEND: begin
        if (lh_if.err_invalid_in) begin
          w_state_nxt     = ST_IDLE;
          w_len_nxt       = 6'd0;
          w_err_abort_nxt = 1'b1;
        end else if (r_gap != 4'd0) begin
          w_gap_nxt = r_gap - 4'd1;
        end else if (r_idx <= w_len_ext) begin
          w_byte_nxt  = w_rd_byte;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = r_idx + 7'd1;
          w_gap_nxt   = GAP;
        end else if (r_idx == w_len_ext + 7'd1) begin
          w_byte_nxt  = TAIL;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = r_idx + 7'd1;
          w_gap_nxt   = GAP;
        end else begin
          w_state_nxt = ST_WAIT;
          w_tmo_nxt   = '0;
        end
      end
      ST_WAIT: begin
        // Core error outranks a same-cycle digest_ready.
        if (lh_if.err_invalid_in || (!lh_if.digest_ready_in && (r_tmo == TMO_LAST))) begin
          w_state_nxt     = ST_IDLE;
          w_len_nxt       = 6'd0;
          w_err_abort_nxt = 1'b1;
        end else if (lh_if.digest_ready_in) begin
          w_state_nxt  = ST_IDLE;
          w_len_nxt    = 6'd0;
          w_digest_nxt = lh_if.digest_in;
          w_done_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= 6'd0;
      r_idx       <= 7'd0;
      r_gap       <= 4'd0;
      r_tmo       <= '0;
      r_byte      <= 8'h00;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_full      <= 1'b0;
      r_digest    <= 64'h0;
      r_done      <= 1'b0;
      r_err_char  <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_gap       <= w_gap_nxt;
      r_tmo       <= w_tmo_nxt;
      r_byte      <= w_byte_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_full      <= (w_len_nxt == LEN_MAX);
      r_digest    <= w_digest_nxt;
      r_done      <= w_done_nxt;
      r_err_char  <= w_err_char_nxt;
      r_err_abort <= w_err_abort_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      r_buf[AW'(r_len)] <= lh_if.wr_data;
    end
  end

  assign lh_if.message_byte  = r_byte;
  assign lh_if.message_valid = r_valid;
  assign lh_if.busy          = r_busy;
  assign lh_if.wr_full       = r_full;
  assign lh_if.msg_len       = r_len;
  assign lh_if.digest_out    = r_digest;
  assign lh_if.done          = r_done;
  assign lh_if.err_char      = r_err_char;
  assign lh_if.err_abort     = r_err_abort;
  assign lh_if.dbg_state     = r_state;
endmodule
